// File: rtl/des_pkg.sv
// Shared types and constants for the Triple-DES control path: FSM states,
// key selectors, round count and the per-round key-schedule rotate amounts.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int DES_ROUNDS = 16;

    localparam logic [1:0] KEY_K1 = 2'd0;
    localparam logic [1:0] KEY_K2 = 2'd1;
    localparam logic [1:0] KEY_K3 = 2'd2;

    // Index 15 is the leftmost entry; encrypt rotates left, decrypt rotates right
    // and skips the rotate on round 0 so it starts from the last encrypt subkey.
    localparam logic [15:0][1:0] ENC_SHIFT = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };
    localparam logic [15:0][1:0] DEC_SHIFT = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
    };

    // EDE key order for a pass; decrypt walks the keys backwards.
    function automatic logic [1:0] pass_key(input logic [1:0] pass, input logic dir,
                                            input int num_passes);
        logic [1:0] k;
        if (num_passes == 1) begin
            k = KEY_K1;
        end else begin
            case (pass)
                2'd0:    k = dir ? KEY_K3 : KEY_K1;
                2'd1:    k = KEY_K2;
                default: k = dir ? KEY_K1 : KEY_K3;
            endcase
        end
        return k;
    endfunction

    // The middle pass runs opposite to the block direction.
    function automatic logic pass_dir(input logic [1:0] pass, input logic dir,
                                      input int num_passes);
        logic d;
        if (num_passes == 1) begin
            d = dir;
        end else begin
            d = dir ^ (pass == 2'd1);
        end
        return d;
    endfunction

endpackage

// File: rtl/tdes_sequencer_if.sv
// Input/output valid-ready handshake of the Triple-DES sequencer.
interface tdes_sequencer_if;
    logic in_valid;
    logic in_ready;
    logic tdes_decrypt;
    logic out_valid;
    logic out_ready;

    modport master (output in_valid, output tdes_decrypt, output out_ready,
                    input in_ready, input out_valid);
    modport slave  (input in_valid, input tdes_decrypt, input out_ready,
                    output in_ready, output out_valid);
endinterface

// File: rtl/des_shift_sched.sv
// Key-schedule C/D rotate amount for a given round and pass direction.
module des_shift_sched
    import des_pkg::*;
(
    input  logic [3:0] round_num,
    input  logic       pass_decrypt,
    output logic [1:0] shift_amt
);

    // Table lookup by direction.
    always_comb begin
        if (pass_decrypt) begin
            shift_amt = DEC_SHIFT[round_num];
        end else begin
            shift_amt = ENC_SHIFT[round_num];
        end
    end

endmodule

// File: rtl/tdes_sequencer.sv
// Control FSM for the iterated Triple-DES datapath: sequences EDE passes of
// Feistel rounds and drives key select, rotate amounts and round strobes.
module tdes_sequencer
    import des_pkg::*;
#(
    parameter int NUM_PASSES = 3,
    parameter int ROUNDS     = DES_ROUNDS
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    tdes_sequencer_if.slave  bus,
    output logic             load_block,
    output logic             load_key,
    output logic [1:0]       key_sel,
    output logic             pass_decrypt,
    output logic [1:0]       pass_num,
    output logic             round_en,
    output logic [3:0]       round_num,
    output logic [1:0]       shift_amt,
    output logic             last_round,
    output logic             busy
);

    seq_state_t state_r, nxt_state_s;
    logic [1:0] pass_r, nxt_pass_s;
    logic [3:0] round_r, nxt_round_s;
    logic       dir_r, nxt_dir_s;
    logic       nxt_pass_dec_s;
    logic [1:0] nxt_key_s;
    logic [1:0] sched_shift_s;

    assign pass_num  = pass_r;
    assign round_num = round_r;

    // Next state and counters; clear overrides every transition.
    always_comb begin
        nxt_state_s = state_r;
        nxt_pass_s  = pass_r;
        nxt_round_s = round_r;
        nxt_dir_s   = dir_r;
        if (clear) begin
            nxt_state_s = ST_IDLE;
            nxt_pass_s  = 2'd0;
            nxt_round_s = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    nxt_pass_s  = 2'd0;
                    nxt_round_s = 4'd0;
                    if (bus.in_valid && bus.in_ready) begin
                        nxt_dir_s   = bus.tdes_decrypt;
                        nxt_state_s = ST_LOAD;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    nxt_state_s = ST_ROUND;
                    nxt_round_s = 4'd0;
                end
                ST_ROUND: begin
                    if (round_r == 4'(ROUNDS - 1)) begin
                        if (pass_r == 2'(NUM_PASSES - 1)) begin
                            nxt_state_s = ST_DONE;
                        end else begin
                            nxt_pass_s  = pass_r + 2'd1;
                            nxt_round_s = 4'd0;
                            nxt_state_s = ST_LOAD;
                        end
                    end else begin
                        nxt_round_s = round_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_valid && bus.out_ready) begin
                        nxt_state_s = ST_IDLE;
                        nxt_pass_s  = 2'd0;
                        nxt_round_s = 4'd0;
                    end else begin
                        nxt_state_s = ST_DONE;
                    end
                end
                default: begin
                    nxt_state_s = ST_IDLE;
                    nxt_pass_s  = 2'd0;
                    nxt_round_s = 4'd0;
                end
            endcase
        end
    end

    // Pass mapping of the upcoming cycle, so outputs can be registered.
    always_comb begin
        nxt_key_s      = pass_key(nxt_pass_s, nxt_dir_s, NUM_PASSES);
        nxt_pass_dec_s = pass_dir(nxt_pass_s, nxt_dir_s, NUM_PASSES);
    end

    des_shift_sched u_shift_sched (
        .round_num    (nxt_round_s),
        .pass_decrypt (nxt_pass_dec_s),
        .shift_amt    (sched_shift_s)
    );

    // State, counters and all outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= ST_IDLE;
            pass_r        <= 2'd0;
            round_r       <= 4'd0;
            dir_r         <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            load_block    <= 1'b0;
            load_key      <= 1'b0;
            key_sel       <= 2'd0;
            pass_decrypt  <= 1'b0;
            round_en      <= 1'b0;
            shift_amt     <= 2'd0;
            last_round    <= 1'b0;
        end else begin
            state_r       <= nxt_state_s;
            pass_r        <= nxt_pass_s;
            round_r       <= nxt_round_s;
            dir_r         <= nxt_dir_s;
            bus.in_ready  <= (nxt_state_s == ST_IDLE);
            bus.out_valid <= (nxt_state_s == ST_DONE);
            busy          <= (nxt_state_s != ST_IDLE);
            load_key      <= (nxt_state_s == ST_LOAD);
            load_block    <= (nxt_state_s == ST_LOAD) && (nxt_pass_s == 2'd0);
            round_en      <= (nxt_state_s == ST_ROUND);
            last_round    <= (nxt_state_s == ST_ROUND) && (nxt_round_s == 4'(ROUNDS - 1));
            if ((nxt_state_s == ST_LOAD) || (nxt_state_s == ST_ROUND)) begin
                key_sel      <= nxt_key_s;
                pass_decrypt <= nxt_pass_dec_s;
            end else begin
                key_sel      <= 2'd0;
                pass_decrypt <= 1'b0;
            end
            if (nxt_state_s == ST_ROUND) begin
                shift_amt <= sched_shift_s;
            end else begin
                shift_amt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_tdes_sequencer.sv
// Directed bench for tdes_sequencer: EDE and single-DES instances side by side.
module tb_tdes_sequencer;

    logic clk;
    logic n_rst;
    logic clear;
    int   n_checks;
    int   n_errors;

    tdes_sequencer_if bus3 ();
    tdes_sequencer_if bus1 ();

    logic       load_block3, load_key3, pass_decrypt3, round_en3, last_round3, busy3;
    logic [1:0] key_sel3, pass_num3, shift_amt3;
    logic [3:0] round_num3;
    logic       load_block1, load_key1, pass_decrypt1, round_en1, last_round1, busy1;
    logic [1:0] key_sel1, pass_num1, shift_amt1;
    logic [3:0] round_num1;

    tdes_sequencer #(.NUM_PASSES(3), .ROUNDS(16)) dut3 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus3.slave),
        .load_block(load_block3), .load_key(load_key3), .key_sel(key_sel3),
        .pass_decrypt(pass_decrypt3), .pass_num(pass_num3), .round_en(round_en3),
        .round_num(round_num3), .shift_amt(shift_amt3), .last_round(last_round3),
        .busy(busy3)
    );

    tdes_sequencer #(.NUM_PASSES(1), .ROUNDS(16)) dut1 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus1.slave),
        .load_block(load_block1), .load_key(load_key1), .key_sel(key_sel1),
        .pass_decrypt(pass_decrypt1), .pass_num(pass_num1), .round_en(round_en1),
        .round_num(round_num1), .shift_amt(shift_amt1), .last_round(last_round1),
        .busy(busy1)
    );

    int enc_sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_sh [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-at-reset outputs of the EDE instance packed together.
    function automatic logic [31:0] quiet3();
        return {15'd0, load_block3, load_key3, key_sel3, pass_decrypt3, pass_num3,
                round_en3, round_num3, shift_amt3, last_round3, busy3, bus3.out_valid};
    endfunction

    // Accept a block on the EDE instance; returns in cycle T+1.
    task automatic accept3(input logic dec);
        bus3.in_valid     = 1'b1;
        bus3.tdes_decrypt = dec;
        step();
        bus3.in_valid = 1'b0;
    endtask

    task automatic run_pass3(input logic dec);
        int ks [3];
        int pd [3];
        int p;
        if (dec) begin
            ks = '{2, 1, 0}; pd = '{1, 0, 1};
        end else begin
            ks = '{0, 1, 2}; pd = '{0, 1, 0};
        end
        accept3(dec);
        for (int c = 1; c <= 53; c++) begin
            if (c > 1) step();
            check("load_block", load_block3, 32'(c == 1));
            check("load_key", load_key3, 32'(c == 1 || c == 18 || c == 35));
            check("round_en", round_en3,
                  32'((c >= 2 && c <= 17) || (c >= 19 && c <= 34) || (c >= 36 && c <= 51)));
            check("last_round", last_round3, 32'(c == 17 || c == 34 || c == 51));
            check("out_valid", bus3.out_valid, 32'(c == 52));
            check("in_ready", bus3.in_ready, 32'(c == 53));
            check("busy", busy3, 32'(c <= 52));
            if (c == 1 || c == 18 || c == 35) begin
                p = (c - 1) / 17;
                check("key_sel", key_sel3, 32'(ks[p]));
                check("pass_decrypt", pass_decrypt3, 32'(pd[p]));
                check("pass_num", pass_num3, 32'(p));
                check("shift_load", shift_amt3, 32'd0);
            end
            if (c >= 2 && c <= 17)
                check("shift_p0", shift_amt3, 32'(dec ? dec_sh[c - 2] : enc_sh[c - 2]));
            if (c >= 19 && c <= 34)
                check("shift_p1", shift_amt3, 32'(dec ? enc_sh[c - 19] : dec_sh[c - 19]));
        end
    endtask

    initial begin
        int  rounds;
        logic seen;
        n_checks = 0;
        n_errors = 0;
        n_rst = 1'b0;
        clear = 1'b0;
        bus3.in_valid = 1'b0; bus3.tdes_decrypt = 1'b0; bus3.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.tdes_decrypt = 1'b0; bus1.out_ready = 1'b1;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", bus3.in_ready, 32'd1);
            check("rst_quiet", quiet3(), 32'd0);
        end
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_in_ready", bus3.in_ready, 32'd1);
            check("idle_quiet", quiet3(), 32'd0);
        end

        // Encrypt then decrypt EDE runs
        run_pass3(1'b0);
        run_pass3(1'b1);

        // Output backpressure with in_valid held
        bus3.out_ready = 1'b0;
        bus3.in_valid = 1'b1;
        bus3.tdes_decrypt = 1'b0;
        step();
        for (int c = 2; c <= 52; c++) step();
        check("bp_first_valid", bus3.out_valid, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_out_valid", bus3.out_valid, 32'd1);
            check("bp_in_ready", bus3.in_ready, 32'd0);
            check("bp_no_accept", load_key3, 32'd0);
        end
        bus3.out_ready = 1'b1;
        bus3.in_valid = 1'b0;
        step();
        check("bp_release_ready", bus3.in_ready, 32'd1);
        check("bp_release_valid", bus3.out_valid, 32'd0);
        check("bp_release_busy", busy3, 32'd0);

        // Clear at pass 1 round 7
        step();
        accept3(1'b0);
        for (int c = 2; c <= 26; c++) step();
        check("clr_pos", {28'd0, pass_num3, round_num3[1:0]}, 32'h7);
        check("clr_round", round_num3, 32'd7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_in_ready", bus3.in_ready, 32'd1);
        check("clr_quiet", quiet3(), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen = seen | bus3.out_valid;
        end
        check("clr_no_out", seen, 32'd0);

        // Async reset at pass 2 round 3
        accept3(1'b0);
        for (int c = 2; c <= 39; c++) step();
        check("rstmid_pass", pass_num3, 32'd2);
        check("rstmid_round", round_num3, 32'd3);
        n_rst = 1'b0;
        #1;
        check("rstmid_in_ready", bus3.in_ready, 32'd1);
        check("rstmid_quiet", quiet3(), 32'd0);
        step();
        step();
        n_rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen = seen | bus3.out_valid;
        end
        check("rstmid_no_out", seen, 32'd0);

        // Single DES instance
        bus1.in_valid = 1'b1;
        bus1.tdes_decrypt = 1'b0;
        step();
        bus1.in_valid = 1'b0;
        rounds = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) step();
            if (round_en1) rounds++;
            if (c == 1) begin
                check("sd_load_block", load_block1, 32'd1);
                check("sd_key_sel", key_sel1, 32'd0);
                check("sd_pass_dec", pass_decrypt1, 32'd0);
            end
            if (round_en1) check("sd_key_round", key_sel1, 32'd0);
            check("sd_last_round", last_round1, 32'(c == 17));
            check("sd_out_valid", bus1.out_valid, 32'(c == 18));
        end
        check("sd_round_count", rounds, 32'd16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
